// File: rtl/gas_detector_multichannel.sv
// Multichannel gas detector front end: per-channel serial framing, W-bit sample
// capture, three-threshold classification, persistence debounce and optional
// latching of the top alarm level. Level is thermometer coded per channel.
module gas_detector_multichannel #(
  parameter int unsigned CH      = 2,
  parameter int unsigned W       = 8,
  parameter int unsigned TH_LOW  = 40,
  parameter int unsigned TH_MID  = 100,
  parameter int unsigned TH_HIGH = 200,
  parameter int unsigned PERSIST = 2,
  parameter int unsigned LATCH   = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [CH-1:0]     din,
  input  logic              clr,
  output logic [3*CH-1:0]   level,
  output logic [W*CH-1:0]   sample,
  output logic [CH-1:0]     frame_vld,
  output logic [CH-1:0]     ferr,
  output logic              alarm_any
);

  localparam int unsigned CW   = $clog2(W);
  localparam logic [W-1:0] THL = W'(TH_LOW);
  localparam logic [W-1:0] THM = W'(TH_MID);
  localparam logic [W-1:0] THH = W'(TH_HIGH);
  localparam logic [3:0]   PCNT = 4'(PERSIST);
  localparam logic [CW-1:0] BLAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_STOP
  } state_t;

  function automatic logic [1:0] classify(input logic [W-1:0] v);
    if (v >= THH)      return 2'd3;
    else if (v >= THM) return 2'd2;
    else if (v >= THL) return 2'd1;
    else               return 2'd0;
  endfunction

  function automatic logic [2:0] encode(input logic [1:0] c);
    case (c)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [1:0] decode(input logic [2:0] l);
    if (l[2])      return 2'd3;
    else if (l[1]) return 2'd2;
    else if (l[0]) return 2'd1;
    else           return 2'd0;
  endfunction

  for (genvar g = 0; g < CH; g++) begin : g_ch
    state_t        state_q, state_d;
    logic [CW-1:0] bcnt_q, bcnt_d;
    logic [W-1:0]  shr_q, shr_d;
    logic [W-1:0]  smp_q, smp_d;
    logic [2:0]    lvl_q, lvl_d;
    logic [1:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          vld_q, vld_d;
    logic          ferr_q, ferr_d;
    logic          good;
    logic [1:0]    cls;
    logic [1:0]    cur;

    // Frame FSM: start bit, W data bits MSB first, stop bit checked for 0
    always_comb begin
      state_d = state_q;
      bcnt_d  = bcnt_q;
      shr_d   = shr_q;
      smp_d   = smp_q;
      vld_d   = 1'b0;
      ferr_d  = 1'b0;
      good    = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (din[g]) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
        S_DATA: begin
          shr_d  = {shr_q[W-2:0], din[g]};
          bcnt_d = bcnt_q + CW'(1);
          if (bcnt_q == BLAST) state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!din[g]) begin
            good  = 1'b1;
            smp_d = shr_q;
            vld_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Persistence filter on good frames; a latched top level freezes the filter; clr overrides
    always_comb begin
      lvl_d  = lvl_q;
      cand_d = cand_q;
      cnt_d  = cnt_q;
      cls    = classify(shr_q);
      cur    = decode(lvl_q);
      if (good && !((LATCH != 0) && (lvl_q == 3'b111))) begin
        if (cls == cur) begin
          cnt_d  = '0;
          cand_d = cls;
        end else if (cls == cand_q) begin
          if (cnt_q + 4'd1 == PCNT) begin
            lvl_d = encode(cls);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cand_d = cls;
          cnt_d  = 4'd1;
          if (PERSIST == 1) lvl_d = encode(cls);
        end
      end
      if (clr) begin
        lvl_d  = '0;
        cand_d = '0;
        cnt_d  = '0;
      end
    end

    // Channel state registers with asynchronous reset
    always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
        state_q <= S_IDLE;
        bcnt_q  <= '0;
        shr_q   <= '0;
        smp_q   <= '0;
        lvl_q   <= '0;
        cand_q  <= '0;
        cnt_q   <= '0;
        vld_q   <= 1'b0;
        ferr_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        bcnt_q  <= bcnt_d;
        shr_q   <= shr_d;
        smp_q   <= smp_d;
        lvl_q   <= lvl_d;
        cand_q  <= cand_d;
        cnt_q   <= cnt_d;
        vld_q   <= vld_d;
        ferr_q  <= ferr_d;
      end
    end

    assign level[3*g +: 3]  = lvl_q;
    assign sample[W*g +: W] = smp_q;
    assign frame_vld[g]     = vld_q;
    assign ferr[g]          = ferr_q;
  end

  // Any channel sitting at the top level raises the shared alarm
  always_comb begin
    alarm_any = 1'b0;
    for (int unsigned i = 0; i < CH; i++) begin
      if (level[3*i +: 3] == 3'b111) alarm_any = 1'b1;
    end
  end

endmodule

// File: tb/tb_gas_detector_multichannel.sv
// Directed bench for gas_detector_multichannel (CH=2, W=8, TH 40/100/200, PERSIST=2, LATCH=1).
module tb_gas_detector_multichannel;

  logic        clk;
  logic        arst;
  logic [1:0]  din;
  logic        clr;
  logic [5:0]  level;
  logic [15:0] sample;
  logic [1:0]  frame_vld;
  logic [1:0]  ferr;
  logic        alarm_any;

  int n_checks;
  int n_fail;

  gas_detector_multichannel #(
    .CH(2), .W(8), .TH_LOW(40), .TH_MID(100), .TH_HIGH(200), .PERSIST(2), .LATCH(1)
  ) dut (
    .clk(clk), .arst(arst), .din(din), .clr(clr),
    .level(level), .sample(sample), .frame_vld(frame_vld), .ferr(ferr),
    .alarm_any(alarm_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    din = 2'b00;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    din  = 2'b00;
    clr  = 1'b0;
    @(posedge clk); #1;
    arst = 1'b0;
    idle(1);
  endtask

  // Drives one 10-cycle frame on each enabled channel; returns #1 after the stop edge.
  task automatic frame(input logic [7:0] v0, input logic [7:0] v1, input logic [1:0] en,
                       input logic [1:0] stopb, input logic clr_at_stop);
    logic [7:0] v [2];
    v[0] = v0;
    v[1] = v1;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 2; c++) begin
        logic b;
        if (k == 0)      b = 1'b1;
        else if (k == 9) b = stopb[c];
        else             b = v[c][8-k];
        din[c] = en[c] ? b : 1'b0;
      end
      if (k == 9 && clr_at_stop) clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
    end
    din = 2'b00;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    arst = 1'b1;
    din  = 2'b00;
    clr  = 1'b0;
    #12;
    check_eq("rst_level", level, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_vld", frame_vld, 0);
    check_eq("rst_ferr", ferr, 0);
    check_eq("rst_alarm", alarm_any, 0);
    @(posedge clk); #1;
    arst = 1'b0;
    idle(1);

    // 1: two frames of 120 on ch0
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t1_vld1", frame_vld, 2'b01);
    check_eq("t1_lvl1", level[2:0], 3'b000);
    check_eq("t1_smp1", sample[7:0], 120);
    idle(1);
    check_eq("t1_vld_off", frame_vld, 2'b00);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t1_vld2", frame_vld, 2'b01);
    check_eq("t1_lvl2", level[2:0], 3'b011);
    check_eq("t1_smp2", sample[7:0], 120);

    // 2: interrupted run resets the candidate
    do_reset();
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    idle(1);
    frame(8'd30, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t2_smp30", sample[7:0], 30);
    idle(1);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t2_lvl_hold", level[2:0], 3'b000);
    idle(1);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t2_lvl_up", level[2:0], 3'b011);

    // 3: framing error on ch1
    idle(1);
    frame(8'd0, 8'd250, 2'b10, 2'b10, 1'b0);
    check_eq("t3_ferr", ferr, 2'b10);
    check_eq("t3_vld", frame_vld, 2'b00);
    check_eq("t3_lvl", level, 6'b000_011);
    check_eq("t3_smp1", sample[15:8], 0);
    idle(1);
    check_eq("t3_ferr_off", ferr, 2'b00);

    // 4: latched top level on ch1, cleared by clr
    frame(8'd0, 8'd250, 2'b10, 2'b00, 1'b0);
    check_eq("t4_lvl_first", level[5:3], 3'b000);
    idle(1);
    frame(8'd0, 8'd250, 2'b10, 2'b00, 1'b0);
    check_eq("t4_lvl_top", level[5:3], 3'b111);
    check_eq("t4_alarm", alarm_any, 1);
    idle(1);
    frame(8'd0, 8'd10, 2'b10, 2'b00, 1'b0);
    idle(1);
    frame(8'd0, 8'd10, 2'b10, 2'b00, 1'b0);
    check_eq("t4_latched", level[5:3], 3'b111);
    check_eq("t4_smp10", sample[15:8], 10);
    check_eq("t4_vld10", frame_vld, 2'b10);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check_eq("t4_clr_lvl", level, 0);
    check_eq("t4_clr_alarm", alarm_any, 0);

    // 7: clr coinciding with a level-changing frame wins
    idle(1);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    idle(1);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b1);
    check_eq("t7_clr_win_lvl", level[2:0], 3'b000);
    check_eq("t7_clr_win_vld", frame_vld, 2'b01);
    idle(1);
    frame(8'd120, 8'd0, 2'b01, 2'b00, 1'b0);
    check_eq("t7_cand_cleared", level[2:0], 3'b000);

    // 5: back-to-back frames on both channels; ch0 candidate is class 2 from above
    idle(1);
    frame(8'd45, 8'd210, 2'b11, 2'b00, 1'b0);
    check_eq("t5_vld1", frame_vld, 2'b11);
    check_eq("t5_lvl1", level, 6'b000_000);
    frame(8'd45, 8'd210, 2'b11, 2'b00, 1'b0);
    check_eq("t5_vld2", frame_vld, 2'b11);
    check_eq("t5_ferr", ferr, 2'b00);
    check_eq("t5_lvl2", level, 6'b111_001);
    check_eq("t5_smp", sample, {8'd210, 8'd45});
    check_eq("t5_alarm", alarm_any, 1);

    // 6: asynchronous reset mid-frame, after start bit and four data bits
    idle(1);
    din = 2'b11;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      din = 2'b11;
      @(posedge clk); #1;
    end
    arst = 1'b1;
    #1;
    check_eq("t6_lvl", level, 0);
    check_eq("t6_smp", sample, 0);
    check_eq("t6_alarm", alarm_any, 0);
    check_eq("t6_vld", frame_vld, 0);
    din = 2'b00;
    @(posedge clk); #1;
    arst = 1'b0;
    idle(1);
    frame(8'd200, 8'd39, 2'b11, 2'b00, 1'b0);
    check_eq("t6_post_vld", frame_vld, 2'b11);
    check_eq("t6_post_smp", sample, {8'd39, 8'd200});
    check_eq("t6_post_ferr", ferr, 2'b00);
    frame(8'd200, 8'd39, 2'b11, 2'b00, 1'b0);
    check_eq("t6_post_lvl", level, 6'b000_111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
